// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz VGA raster timing with pixel enable, sync, blanking, frame_end and optional game tick
// Ports:
//   clk        system clock (CLK_DIV clocks per pixel)
//   rst_n      asynchronous active-low reset
//   pixel_tick one-clk pulse per pixel, high the cycle after the counters advance
//   pixel_x    horizontal count 0..H_TOTAL-1 (includes blanking)
//   pixel_y    vertical count 0..V_TOTAL-1 (includes blanking)
//   hsync      horizontal sync, active low
//   vsync      vertical sync, active low
//   video_on   high inside the visible area
//   frame_end  one-clk pulse when the raster leaves the last visible pixel
//   game_tick  one-clk pulse every GAME_DIV frames when VGA_GAME_TICK_EN is defined, else 0
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int GAME_DIV  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_end,
  output logic       game_tick
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP = 10'(V_DISPLAY);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_LO  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  logic [DW-1:0] div;
  logic          adv;
  logic          h_wrap;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          fe_nxt;
  // Sync/blank flags are decoded from the next counter values so they register
  // on the same edge as pixel_x/pixel_y and stay aligned with them.
  always_comb begin
    adv    = div == DIV_MAX;
    h_wrap = adv && pixel_x == H_MAX;
    h_nxt  = adv ? (h_wrap ? 10'd0 : pixel_x + 10'd1) : pixel_x;
    v_nxt  = h_wrap ? (pixel_y == V_MAX ? 10'd0 : pixel_y + 10'd1) : pixel_y;
    fe_nxt = adv && h_nxt == H_DISP && v_nxt == V_LAST;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      pixel_tick <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b1;
      frame_end  <= 1'b0;
    end else begin
      div        <= adv ? '0 : div + DW'(1);
      pixel_tick <= adv;
      pixel_x    <= h_nxt;
      pixel_y    <= v_nxt;
      hsync      <= !(h_nxt >= HS_LO && h_nxt <= HS_HI);
      vsync      <= !(v_nxt >= VS_LO && v_nxt <= VS_HI);
      video_on   <= h_nxt < H_DISP && v_nxt < V_DISP;
      frame_end  <= fe_nxt;
    end
  end
`ifdef VGA_GAME_TICK_EN
  localparam int GW = GAME_DIV > 1 ? $clog2(GAME_DIV) : 1;
  localparam logic [GW-1:0] G_MAX = GW'(GAME_DIV - 1);
  logic [GW-1:0] frame_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      game_tick <= 1'b0;
    end else begin
      game_tick <= fe_nxt && frame_cnt == G_MAX;
      if (fe_nxt) frame_cnt <= frame_cnt == G_MAX ? '0 : frame_cnt + GW'(1);
    end
  end
`else
  assign game_tick = 1'b0 && GAME_DIV > 0;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized reset/run bench for vga_sync_gen against an arithmetic raster model
module tb_vga_sync_gen;
  localparam int CD = 4;
  localparam int HD = 20, HF = 3, HS = 5, HB = 4;
  localparam int VD = 6, VF = 2, VS = 2, VB = 3;
  localparam int GD = 15;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int K0 = (VD - 1) * HT + HD;
  logic       clk;
  logic       rst_n;
  logic       pixel_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_end;
  logic       game_tick;
  logic [25:0] obs;
  int n;
  int total;
  int passed;
  vga_sync_gen #(
    .CLK_DIV(CD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .GAME_DIV(GD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_end(frame_end), .game_tick(game_tick)
  );
  assign obs = {pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_end, game_tick};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Expected outputs after the n-th rising edge since reset release, derived
  // from total pixel count n/CD rather than from any counter state.
  function automatic logic [25:0] model(input int cyc);
    int p, h, v, f;
    logic tk, hs_n, vs_n, vo, fe, gt;
    p    = cyc / CD;
    tk   = cyc > 0 && cyc % CD == 0;
    h    = p % HT;
    v    = (p / HT) % VT;
    hs_n = !(h >= HD + HF && h < HD + HF + HS);
    vs_n = !(v >= VD + VF && v < VD + VF + VS);
    vo   = h < HD && v < VD;
    fe   = tk && h == HD && v == VD - 1;
    f    = p >= K0 ? (p - K0) / FT + 1 : 0;
`ifdef VGA_GAME_TICK_EN
    gt   = fe && f % GD == 0;
`else
    gt   = 1'b0;
`endif
    return {tk, 10'(h), 10'(v), hs_n, vs_n, vo, fe, gt};
  endfunction
  task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s n=%0d got tick=%b x=%0d y=%0d hs=%b vs=%b vo=%b fe=%b gt=%b expected tick=%b x=%0d y=%0d hs=%b vs=%b vo=%b fe=%b gt=%b",
                  tag, n, got[25], got[24:15], got[14:5], got[4], got[3], got[2], got[1], got[0],
                  exp[25], exp[24:15], exp[14:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
  endtask
  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check("raster", obs, model(n));
    end
  endtask
  initial begin
    total  = 0;
    passed = 0;
    n      = 0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", obs, model(0));
    rst_n = 1'b1;
    run(31 * FT * CD + 50);
    for (int s = 0; s < 6; s++) begin
      #($urandom_range(1, 4));
      rst_n = 1'b0;
      #1;
      check("async_reset", obs, model(0));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check("reset_hold", obs, model(0));
      n     = 0;
      rst_n = 1'b1;
      run($urandom_range(100, 2500));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
